// File: rtl/master_source_responder.sv
// Data-source responder playing the external master: offers a word stream on
// master_data/master_busy and consumes master_req, with programmable length,
// inter-word busy gap and increment/LFSR word generation.
module master_source_responder #(
  parameter int                DATA_W    = 32,
  parameter int                GAP_W     = 8,
  parameter int                LEN_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = 32'h80200003
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              master_req,
  output logic [DATA_W-1:0] master_data,
  output logic              master_busy,
  output logic [LEN_W-1:0]  words_sent,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READY, GAP, DONE} state_t;

  state_t             state, state_next;
  logic               mode_q;
  logic [GAP_W-1:0]   gap_q;
  logic [LEN_W-1:0]   len_q;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
  logic [DATA_W-1:0]  data_next;
  logic [LEN_W-1:0]   words_next;
  logic               busy_next;
  logic               done_next;
  logic               xfer;
  logic               last_word;
  logic [LEN_W-1:0]   sent_inc;
  logic [DATA_W-1:0]  seed_load;

  // Next word of the stream: plain increment, or one Galois LFSR shift.
  function automatic logic [DATA_W-1:0] next_word(input logic mode,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    if (mode) begin
      r = d >> 1;
      if (d[0]) r = r ^ LFSR_POLY;
    end else begin
      r = d + 1'b1;
    end
    return r;
  endfunction

  assign xfer      = (state == READY) && master_req;
  assign sent_inc  = words_sent + 1'b1;
  assign last_word = (len_q != '0) && (sent_inc == len_q);
  assign seed_load = (cfg_mode && (cfg_seed == '0)) ? DATA_W'(1) : cfg_seed;

  // State register plus all registered outputs and latched configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      master_busy <= 1'b1;
      master_data <= '0;
      words_sent  <= '0;
      done        <= 1'b0;
      gap_cnt     <= '0;
      mode_q      <= 1'b0;
      gap_q       <= '0;
      len_q       <= '0;
    end else begin
      state       <= state_next;
      master_busy <= busy_next;
      master_data <= data_next;
      words_sent  <= words_next;
      done        <= done_next;
      gap_cnt     <= gap_cnt_next;
      if (cfg_start) begin
        mode_q <= cfg_mode;
        gap_q  <= cfg_gap;
        len_q  <= cfg_len;
      end
    end
  end

  // Next-state decision; a start pulse overrides everything, including a transfer.
  always_comb begin
    state_next = state;
    if (cfg_start) begin
      state_next = READY;
    end else begin
      case (state)
        READY: begin
          if (xfer) begin
            if (last_word)        state_next = DONE;
            else if (gap_q == '0) state_next = READY;
            else                  state_next = GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(1)) state_next = READY;
        end
        default: state_next = state;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the chosen next state.
  always_comb begin
    data_next    = master_data;
    words_next   = words_sent;
    gap_cnt_next = gap_cnt;
    busy_next    = (state_next != READY);
    done_next    = (state_next == DONE);
    if (cfg_start) begin
      data_next    = seed_load;
      words_next   = '0;
      gap_cnt_next = '0;
    end else if (xfer) begin
      data_next    = next_word(mode_q, master_data);
      words_next   = sent_inc;
      gap_cnt_next = gap_q;
    end else if (state == GAP) begin
      gap_cnt_next = gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_master_source_responder.sv
// Directed bench for master_source_responder: stream length, gaps, LFSR mode,
// wraparound, restart precedence and asynchronous reset.
module tb_master_source_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_mode;
  logic [31:0] cfg_seed;
  logic [7:0]  cfg_gap;
  logic [15:0] cfg_len;
  logic        master_req;
  logic [31:0] master_data;
  logic        master_busy;
  logic [15:0] words_sent;
  logic        done;

  int checks   = 0;
  int failures = 0;

  master_source_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_mode   (cfg_mode),
    .cfg_seed   (cfg_seed),
    .cfg_gap    (cfg_gap),
    .cfg_len    (cfg_len),
    .master_req (master_req),
    .master_data(master_data),
    .master_busy(master_busy),
    .words_sent (words_sent),
    .done       (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic [31:0] seed,
                               input logic [7:0] gap, input logic [15:0] len,
                               input logic req);
    cfg_mode   = mode;
    cfg_seed   = seed;
    cfg_gap    = gap;
    cfg_len    = len;
    master_req = req;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_seed = '0;
    cfg_gap = '0; cfg_len = '0; master_req = 1'b0;
    #3;
    checkOutput("rst_busy",  32'(master_busy), 32'd1);
    checkOutput("rst_data",  master_data,      32'd0);
    checkOutput("rst_words", 32'(words_sent),  32'd0);
    checkOutput("rst_done",  32'(done),        32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(master_busy), 32'd1);

    // Incrementing stream of 4 words, back-to-back.
    $display("[TB] step 1: increment, len=4, gap=0");
    applyStimulus(1'b0, 32'd5, 8'd0, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("s1_data", master_data,       32'd5 + 32'(i));
      checkOutput("s1_busy", 32'(master_busy),  32'd0);
      checkOutput("s1_words", 32'(words_sent),  32'(i));
      tick();
    end
    checkOutput("s1_done",      32'(done),        32'd1);
    checkOutput("s1_done_busy", 32'(master_busy), 32'd1);
    checkOutput("s1_words_end", 32'(words_sent),  32'd4);
    checkOutput("s1_data_end",  master_data,      32'd9);
    tick();
    checkOutput("s1_done_hold", 32'(words_sent),  32'd4);

    // Gap of 3 busy cycles after each word, length 2.
    $display("[TB] step 2: gap=3, len=2");
    applyStimulus(1'b0, 32'd100, 8'd3, 16'd2, 1'b1);
    checkOutput("s2_first", master_data, 32'd100);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("s2_gap_busy", 32'(master_busy), 32'd1);
      tick();
    end
    checkOutput("s2_ready_busy", 32'(master_busy), 32'd0);
    checkOutput("s2_words1",     32'(words_sent),  32'd1);
    checkOutput("s2_data2",      master_data,      32'd101);
    tick();
    checkOutput("s2_words2", 32'(words_sent), 32'd2);
    checkOutput("s2_done",   32'(done),       32'd1);

    // LFSR mode with zero seed; req held while busy must be ignored.
    $display("[TB] step 3: LFSR, seed=0");
    applyStimulus(1'b1, 32'd0, 8'd2, 16'd0, 1'b0);
    checkOutput("s3_first", master_data, 32'd1);
    master_req = 1'b1;
    tick();
    checkOutput("s3_gap_busy", 32'(master_busy), 32'd1);
    tick();
    master_req = 1'b0;
    tick();
    checkOutput("s3_words",  32'(words_sent),  32'd1);
    checkOutput("s3_second", master_data,      32'h80200003);
    checkOutput("s3_busy",   32'(master_busy), 32'd0);
    master_req = 1'b1;
    tick();
    checkOutput("s3_third", master_data,     32'hC0300002);
    checkOutput("s3_words2", 32'(words_sent), 32'd2);

    // Unlimited stream wrapping past all-ones.
    $display("[TB] step 4: unlimited, wrap");
    applyStimulus(1'b0, 32'hFFFF_FFFE, 8'd0, 16'd0, 1'b1);
    checkOutput("s4_w0", master_data, 32'hFFFF_FFFE);
    tick();
    checkOutput("s4_w1", master_data, 32'hFFFF_FFFF);
    tick();
    checkOutput("s4_w2",    master_data,      32'd0);
    checkOutput("s4_done",  32'(done),        32'd0);
    checkOutput("s4_words", 32'(words_sent),  32'd2);

    // Start coinciding with a request in READY wins over the transfer.
    $display("[TB] step 5: restart precedence");
    applyStimulus(1'b0, 32'h1234, 8'd2, 16'd5, 1'b1);
    checkOutput("s5_data",  master_data,      32'h1234);
    checkOutput("s5_words", 32'(words_sent),  32'd0);
    checkOutput("s5_busy",  32'(master_busy), 32'd0);
    tick();
    checkOutput("s5_in_gap", 32'(master_busy), 32'd1);
    applyStimulus(1'b0, 32'hABCD, 8'd2, 16'd5, 1'b1);
    checkOutput("s5_gap_data",  master_data,      32'hABCD);
    checkOutput("s5_gap_words", 32'(words_sent),  32'd0);
    checkOutput("s5_gap_busy",  32'(master_busy), 32'd0);

    // Asynchronous reset in the middle of a gap.
    $display("[TB] step 6: reset mid-gap");
    tick();
    checkOutput("s6_pre_busy", 32'(master_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("s6_busy",  32'(master_busy), 32'd1);
    checkOutput("s6_data",  master_data,      32'd0);
    checkOutput("s6_words", 32'(words_sent),  32'd0);
    checkOutput("s6_done",  32'(done),        32'd0);
    tick();
    rst = 1'b0;
    master_req = 1'b0;
    tick();
    tick();
    checkOutput("s6_idle_busy", 32'(master_busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
